serial_subtractor_8bits: RTL and testbench

SERIAL_SUBTRACTOR_8BITS -- requirements
Module: serial_subtractor_8bits

---
 rtl/serial_subtractor_8bits.sv | 110 +++++++++++
 tb/tb_serial_subtractor_8bits.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial 8-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow flag V is compiled in with `define SUB_OVERFLOW_FLAG_EN.
module serial_subtractor_8bits (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bin,
  output logic [7:0] D,
  output logic       Bout,
  output logic       Z,
  output logic       busy,
  output logic       done
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic       V
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [7:0] work;
  logic       br;
  logic [2:0] cnt;

  logic       d_bit;
  logic       br_next;
  logic [7:0] work_next;

  // Full-subtractor cell on the current LSBs of the captured operands.
  assign d_bit     = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
  assign work_next = {d_bit, work[7:1]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath shift registers are reset too, which keeps
  // them out of X in simulation and costs nothing here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= 8'h00;
      b_sh  <= 8'h00;
      work  <= 8'h00;
      br    <= 1'b0;
      cnt   <= 3'd0;
      D     <= 8'h00;
      Bout  <= 1'b0;
      Z     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          work <= work_next;
          cnt  <= cnt + 3'd1;
          // Last bit: publish the whole result at once so D never shows partials.
          if (cnt == 3'd7) begin
            D     <= work_next;
            Bout  <= br_next;
            Z     <= (work_next == 8'h00);
`ifdef SUB_OVERFLOW_FLAG_EN
            V     <= br ^ br_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits: directed table, corner
// sequences (ignored start, held start, mid-operation reset) and random ops.
module tb_serial_subtractor_8bits;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic [7:0] D;
  logic       Bout;
  logic       Z;
  logic       busy;
  logic       done;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic       V;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  serial_subtractor_8bits dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .D    (D),
    .Bout (Bout),
    .Z    (Z),
    .busy (busy),
    .done (done)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .V    (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bout;
    logic       exp_z;
    logic       exp_v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bout, output logic z, output logic v);
    int diff;
    int sdiff;
    diff  = int'(a) - int'(b) - int'(bin);
    sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d     = diff[7:0];
    bout  = (diff < 0);
    z     = (d == 8'h00);
    v     = (sdiff < -128) || (sdiff > 127);
  endtask

  // Issue one start pulse and follow the operation to its done pulse.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input string name, input logic check_v, input logic mess_up);
    logic [7:0] ed;
    logic       eb, ez, ev;
    logic [7:0] prev_d;
    int         busy_cycles;
    int         wait_cycles;
    logic       got_done;
    logic       d_stable;
    model(a, b, bin, ed, eb, ez, ev);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_d = D;
    busy_cycles = 0; wait_cycles = 0; got_done = 1'b0; d_stable = 1'b1;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (D !== prev_d) d_stable = 1'b0;
        if (mess_up && i == 2) begin
          A = ~a; B = a; Bin = ~bin; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        wait_cycles++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(got_done), 32'd1);
    check({name, " latency"}, 32'(wait_cycles), 32'd8);
    check({name, " busy_cycles"}, 32'(busy_cycles), 32'd8);
    check({name, " d_held"}, 32'(d_stable), 32'd1);
    check({name, " D"}, 32'(D), 32'(ed));
    check({name, " Bout"}, 32'(Bout), 32'(eb));
    check({name, " Z"}, 32'(Z), 32'(ez));
`ifdef SUB_OVERFLOW_FLAG_EN
    if (check_v) check({name, " V"}, 32'(V), 32'(ev));
`else
    if (check_v && ev === 1'bx) check({name, " V_model"}, 32'(ev), 32'd0);
`endif
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " idle_not_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int done_count;
    int first_done;
    int second_done;
    logic [7:0] ra, rb;
    logic       rbin;

    vecs[0] = '{8'h2D, 8'h21, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h21, 8'h2D, 1'b0, 8'hF4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h67, 8'h67, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    #12;
    check("reset D", 32'(D), 32'h00);
    check("reset Bout", 32'(Bout), 32'd0);
    check("reset Z", 32'(Z), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
    check("reset V", 32'(V), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed table: expected values are the hand-computed constants above.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), 1'b1, 1'b0);
      check($sformatf("vec%0d D_table", i), 32'(D), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d Bout_table", i), 32'(Bout), 32'(vecs[i].exp_bout));
      check($sformatf("vec%0d Z_table", i), 32'(Z), 32'(vecs[i].exp_z));
`ifdef SUB_OVERFLOW_FLAG_EN
      check($sformatf("vec%0d V_table", i), 32'(V), 32'(vecs[i].exp_v));
`endif
    end

    // Second start and operand changes during SHIFT must be ignored.
    run_op(8'h2D, 8'h21, 1'b1, "ignore_start", 1'b1, 1'b1);
    done_count = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) done_count++;
      @(negedge clk);
    end
    check("ignore_start extra_done", 32'(done_count), 32'd0);
    check("ignore_start D_kept", 32'(D), 32'h0B);

    // Held start: one result every 10 cycles.
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int i = 0; i < 40 && second_done < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
    end
    start = 1'b0;
    check("held_start period", 32'(second_done - first_done), 32'd10);
    check("held_start D", 32'(D), 32'h0F);
    repeat (3) @(negedge clk);

    // Reset on the 4th SHIFT cycle aborts with no done pulse.
    @(negedge clk);
    A = 8'h55; B = 8'h22; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort D", 32'(D), 32'h00);
    check("abort Z", 32'(Z), 32'd1);
    check("abort Bout", 32'(Bout), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < 14; i++) begin
      if (done || busy) done_count++;
      @(negedge clk);
    end
    check("abort no_done", 32'(done_count), 32'd0);
    run_op(8'h55, 8'h22, 1'b0, "after_abort", 1'b1, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, $sformatf("rand%0d", i), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
